serial_addsub8: RTL

- Bit-serial 8-bit add/subtract unit for the 8-bit datapath.
- Feeds one full_adder instance one operand bit pair per clock, LSB first, and registers its carry between cycles.
- Sits between the register-file read stage and the writeback/flags logic.
- A low-area alternative to a ripple-carry ALU path; the result is committed with a one-cycle done pulse.

---
 rtl/serial_addsub8.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_addsub8.sv
// serial_addsub8: bit-serial add/subtract stepping one full_adder per clock, LSB first.
// Build option SERIAL_ADDSUB_CARRY_IN_EN adds a cin port that seeds the carry (ADC/SBC chaining).
module serial_addsub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_CARRY_IN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             carry_init;
  logic             fa_sum;
  logic             fa_cout;

`ifdef SERIAL_ADDSUB_CARRY_IN_EN
  assign carry_init = cin;
`else
  assign carry_init = sub;
`endif

  full_adder u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= carry_init;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          res_sr <= res_next;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB here, so it is c_msb
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= res_next;
            carry_out <= fa_cout;
            overflow  <= carry ^ fa_cout;
            zero      <= (res_next == '0);
            negative  <= res_next[WIDTH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// One-bit full adder used by the serial datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule
